cct_exerciser: RTL and testbench
================================

Name: cct_exerciser

Overview:
- Stimulus and response end of the 8-bit circuit-under-test interface (clk, clear, cct_input[7:0] into the circuit, cct_output[7:0] out of it).
- On a start pulse it:
  - clears the circuit;
  - drives a pseudo-random LFSR vector stream into cct_input;
  - compacts the returned cct_output stream into an 8-bit MISR signature;
  - compares the signature against an expected value.
- Sits on the board beside the circuit under test, for self-checking runs without a simulator.

Parameters:
- NUM_VECTORS, 64: number of vectors driven per run (1..255).
- CLEAR_CYCLES, 2: cycles cct_clear is held high before driving (>=1).
- LATENCY, 1: clock cycles from cct_input applied to matching cct_output valid (1..8).
- SEED, 8'h01: LFSR value loaded at reset and at every start; must be nonzero.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- clear_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle run request; ignored while busy.
- expected_sig  input  8  golden signature, sampled in DONE.
- cct_clear  output  1  clear to the circuit under test.
- cct_input  output  8  vector driven to the circuit under test.
- cct_output  input  8  response from the circuit under test.
- busy  output  1  high from the cycle after start is accepted until DONE is left.
- done  output  1  one-cycle pulse at end of run.
- pass  output  1  signature == expected_sig; valid from done, held until next start.
- signature  output  8  MISR contents; final value held until next start.
- vec_count  output  8  vectors driven so far in the current run.

Behaviour:
- Reset (clear_n low, asynchronous):
  - state IDLE, lfsr = SEED, signature = 0, vec_count = 0, capture pipe = 0;
  - all outputs 0.
- States: IDLE -> CLEAR -> DRIVE -> DRAIN -> DONE -> IDLE.
- IDLE:
  - start=1 -> CLEAR next cycle; at the same edge load lfsr = SEED, signature = 0, vec_count = 0, pass = 0.
- CLEAR:
  - cct_clear = 1, cct_input = 0, for exactly CLEAR_CYCLES cycles, then DRIVE.
- DRIVE, exactly NUM_VECTORS cycles:
  - cct_input = lfsr (registered output); first vector = SEED.
  - Each cycle: lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}, and vec_count increments.
  - cct_clear = 0.
- DRAIN:
  - exactly LATENCY cycles, cct_input = 0, then DONE.
- DONE:
  - single cycle: done = 1, pass <= (signature == expected_sig), then IDLE.
  - busy is high in CLEAR, DRIVE, DRAIN and DONE.
- Capture:
  - a drive_valid bit delayed through a LATENCY-deep shift register gives cap_en.
  - When cap_en = 1: signature <= {signature[6:0], signature[7]^signature[5]^signature[4]^signature[3]} ^ cct_output.
  - Exactly NUM_VECTORS captures per run, the last one in the final DRAIN cycle.
  - No capture during CLEAR or outside a run.
- Outside DRIVE, cct_input is 0.
- start while busy: ignored; no restart, no effect on the counters.
- start in the DONE cycle: ignored. A start in the cycle after DONE is accepted.
- Reset mid-run: immediate return to IDLE with the reset values. cct_clear drops with no glitch beyond the async clear.
- pass and signature persist after IDLE is re-entered until the next accepted start.

Test Plan:
- Vector stream: SEED=01, cct_output looped to a 1-cycle register of cct_input.
  - cct_input sequence in DRIVE = 01,02,04,08,11,23,...
  - vec_count reaches 64.
  - done pulses exactly CLEAR_CYCLES+64+LATENCY+1 cycles after the start cycle, i.e. 68 cycles.
- Constant response: cct_output tied 8'h00, expected_sig=00 -> signature=00, pass=1.
  - Repeat with expected_sig=5A -> pass=0.
- MISR arithmetic: NUM_VECTORS=1, cct_output=FF -> signature=FF.
  - NUM_VECTORS=2, cct_output=FF -> signature=01.
- Clear phase: CLEAR_CYCLES=3 -> cct_clear high exactly 3 cycles, starting the cycle after start.
  - cct_input = 0 and no capture during those cycles.
- Start handling: start pulsed mid-DRIVE and in the DONE cycle -> ignored, single done pulse.
  - start on the cycle after done -> new run begins, signature reset to 0.
- Reset mid-run: clear_n low during DRIVE at vec_count=10 -> asynchronous return to IDLE with all outputs 0.
  - A subsequent start produces an identical signature to an uninterrupted run.

Source files
------------

// File: rtl/cct_exerciser.sv
// Self-test exerciser for an 8-bit circuit under test: clears it, drives an LFSR
// vector stream into it, folds the responses into a MISR signature and checks it.
module cct_exerciser #(
  parameter int         NUM_VECTORS  = 64,
  parameter int         CLEAR_CYCLES = 2,
  parameter int         LATENCY      = 1,
  parameter logic [7:0] SEED         = 8'h01
) (
  input  logic       clk,
  input  logic       clear_n,
  input  logic       start,
  input  logic [7:0] expected_sig,
  output logic       cct_clear,
  output logic [7:0] cct_input,
  input  logic [7:0] cct_output,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] signature,
  output logic [7:0] vec_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    DRIVE = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Shared feedback taps (bits 7,5,4,3) for both the LFSR and the MISR.
  function automatic logic fb_parity(input logic [7:0] v);
    return v[7] ^ v[5] ^ v[4] ^ v[3];
  endfunction

  function automatic logic [7:0] shift_fb(input logic [7:0] v);
    return {v[6:0], fb_parity(v)};
  endfunction

  state_t             state_r;
  logic [7:0]         lfsr_r;
  logic [7:0]         cnt_r;
  logic [7:0]         cct_input_r;
  logic [7:0]         signature_r;
  logic [7:0]         vec_count_r;
  logic               cct_clear_r;
  logic               busy_r;
  logic               done_r;
  logic               pass_r;
  logic               drive_valid_r;
  logic [LATENCY-1:0] cap_pipe_r;
  logic               start_accept_s;
  logic               cap_en_s;

  assign start_accept_s = (state_r == IDLE) && start;
  assign cap_en_s       = cap_pipe_r[LATENCY-1];

  assign cct_clear = cct_clear_r;
  assign cct_input = cct_input_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign pass      = pass_r;
  assign signature = signature_r;
  assign vec_count = vec_count_r;

  // Run sequencer: phase control, vector generation and registered handshake outputs.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_r       <= IDLE;
      lfsr_r        <= SEED;
      cnt_r         <= 8'd0;
      cct_input_r   <= 8'd0;
      vec_count_r   <= 8'd0;
      cct_clear_r   <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      pass_r        <= 1'b0;
      drive_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_accept_s) begin
            state_r     <= CLEAR;
            lfsr_r      <= SEED;
            cnt_r       <= 8'd0;
            vec_count_r <= 8'd0;
            pass_r      <= 1'b0;
            busy_r      <= 1'b1;
            cct_clear_r <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        CLEAR: begin
          if (cnt_r == 8'(CLEAR_CYCLES - 1)) begin
            state_r       <= DRIVE;
            cct_clear_r   <= 1'b0;
            cct_input_r   <= lfsr_r;
            lfsr_r        <= shift_fb(lfsr_r);
            vec_count_r   <= vec_count_r + 8'd1;
            drive_valid_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        DRIVE: begin
          // vec_count already counts the vector on the bus, so N means the last one is out.
          if (vec_count_r == 8'(NUM_VECTORS)) begin
            state_r       <= DRAIN;
            cct_input_r   <= 8'd0;
            drive_valid_r <= 1'b0;
            cnt_r         <= 8'd0;
          end else begin
            cct_input_r <= lfsr_r;
            lfsr_r      <= shift_fb(lfsr_r);
            vec_count_r <= vec_count_r + 8'd1;
          end
        end
        DRAIN: begin
          if (cnt_r == 8'(LATENCY - 1)) begin
            state_r <= DONE;
            done_r  <= 1'b1;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        DONE: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          pass_r  <= (signature_r == expected_sig);
        end
        default: begin
          state_r       <= IDLE;
          cct_clear_r   <= 1'b0;
          cct_input_r   <= 8'd0;
          busy_r        <= 1'b0;
          done_r        <= 1'b0;
          drive_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Response capture: drive_valid delayed by the circuit latency gates the MISR.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      cap_pipe_r  <= '0;
      signature_r <= 8'd0;
    end else begin
      cap_pipe_r <= (cap_pipe_r << 1) | LATENCY'(drive_valid_r);
      if (start_accept_s) begin
        signature_r <= 8'd0;
      end else if (cap_en_s) begin
        signature_r <= shift_fb(signature_r) ^ cct_output;
      end else begin
        signature_r <= signature_r;
      end
    end
  end

endmodule

// File: tb/tb_cct_exerciser.sv
// Bench for cct_exerciser: three parameterisations driven with looped-back, constant
// and random responses, checked against a cycle-timeline and signature reference model.
module tb_cct_exerciser;

  localparam int NI = 3;

  logic       clk = 1'b0;
  logic       clear_n;
  logic       start     [NI];
  logic [7:0] exp_sig   [NI];
  logic       cclr      [NI];
  logic [7:0] cin       [NI];
  logic [7:0] cout      [NI];
  logic       busy      [NI];
  logic       done      [NI];
  logic       pass      [NI];
  logic [7:0] sig       [NI];
  logic [7:0] vcnt      [NI];
  logic [7:0] drv       [NI];
  logic [7:0] lb        [NI];
  logic       loop_mode [NI];
  logic [7:0] hist      [NI][4096];
  int         tick = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] ref_sig;
  logic [7:0] tmp_sig;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NI; i++) cout[i] = loop_mode[i] ? lb[i] : drv[i];
  end

  // Loopback circuit: a one-cycle register of cct_input.
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) lb[i] <= cin[i];
  end

  // Record the response present in each cycle, as seen at the closing edge.
  always @(posedge clk) begin
    if (tick < 4096) begin
      for (int i = 0; i < NI; i++) hist[i][tick] = cout[i];
    end
    tick = tick + 1;
  end

  cct_exerciser #(.NUM_VECTORS(64), .CLEAR_CYCLES(2), .LATENCY(1), .SEED(8'h01)) dut_a (
    .clk(clk), .clear_n(clear_n), .start(start[0]), .expected_sig(exp_sig[0]),
    .cct_clear(cclr[0]), .cct_input(cin[0]), .cct_output(cout[0]), .busy(busy[0]),
    .done(done[0]), .pass(pass[0]), .signature(sig[0]), .vec_count(vcnt[0]));

  cct_exerciser #(.NUM_VECTORS(2), .CLEAR_CYCLES(3), .LATENCY(3), .SEED(8'h01)) dut_b (
    .clk(clk), .clear_n(clear_n), .start(start[1]), .expected_sig(exp_sig[1]),
    .cct_clear(cclr[1]), .cct_input(cin[1]), .cct_output(cout[1]), .busy(busy[1]),
    .done(done[1]), .pass(pass[1]), .signature(sig[1]), .vec_count(vcnt[1]));

  cct_exerciser #(.NUM_VECTORS(1), .CLEAR_CYCLES(1), .LATENCY(1), .SEED(8'h01)) dut_c (
    .clk(clk), .clear_n(clear_n), .start(start[2]), .expected_sig(exp_sig[2]),
    .cct_clear(cclr[2]), .cct_input(cin[2]), .cct_output(cout[2]), .busy(busy[2]),
    .done(done[2]), .pass(pass[2]), .signature(sig[2]), .vec_count(vcnt[2]));

  // Shift left one place, new LSB = parity of bits 7,5,4,3 (mask 8'hB8).
  function automatic logic [7:0] fb_step(input logic [7:0] v);
    return ((v << 1) & 8'hFE) | {7'd0, ^(v & 8'hB8)};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input int id);
    check("rst_clear", 8'(cclr[id]), 8'd0);
    check("rst_input", cin[id], 8'd0);
    check("rst_busy", 8'(busy[id]), 8'd0);
    check("rst_done", 8'(done[id]), 8'd0);
    check("rst_pass", 8'(pass[id]), 8'd0);
    check("rst_sig", sig[id], 8'd0);
    check("rst_vcnt", vcnt[id], 8'd0);
  endtask

  // One full run from an accepted start to the idle cycle right after done.
  task automatic run(input int id, input int n, input int c, input int l,
                     input bit lbk, input bit cst, input logic [7:0] cval,
                     input bit use_model, input logic [7:0] efix, input bit inject,
                     output logic [7:0] sig_out);
    int         base;
    int         last;
    int         done_at;
    logic [7:0] lf;
    logic [7:0] model;
    logic [7:0] expv;
    logic       exp_pass;
    done_at  = c + n + l + 1;
    last     = done_at + 1;
    lf       = 8'h01;
    model    = 8'd0;
    exp_pass = 1'b0;
    loop_mode[id] = lbk;
    start[id] = 1'b1;
    step();
    start[id] = 1'b0;
    base = tick - 1;
    for (int o = 1; o <= last; o++) begin
      start[id] = inject && (o == c + 3 || o == done_at);
      drv[id]   = cst ? cval : 8'($urandom);
      if (o == done_at) begin
        // Response to vector k arrives l cycles after the vector's own cycle c+1+k.
        model = 8'd0;
        for (int k = 0; k < n; k++) model = fb_step(model) ^ hist[id][base + c + 1 + k + l];
        expv        = use_model ? model : efix;
        exp_sig[id] = expv;
        exp_pass    = (model == expv);
      end else begin
        exp_sig[id] = 8'($urandom);
      end
      check("cct_clear", 8'(cclr[id]), 8'(o <= c));
      if (o > c && o <= c + n) begin
        check("cct_input", cin[id], lf);
        lf = fb_step(lf);
      end else begin
        check("cct_input_idle", cin[id], 8'd0);
      end
      check("vec_count", vcnt[id], (o <= c) ? 8'd0 : ((o <= c + n) ? 8'(o - c) : 8'(n)));
      check("busy", 8'(busy[id]), 8'(o <= done_at));
      check("done", 8'(done[id]), 8'(o == done_at));
      if (o <= c) check("sig_in_clear", sig[id], 8'd0);
      if (o <= done_at) check("pass_low", 8'(pass[id]), 8'd0);
      if (o >= done_at) check("signature", sig[id], model);
      if (o == last) check("pass", 8'(pass[id]), 8'(exp_pass));
      if (o < last) step();
    end
    start[id] = 1'b0;
    sig_out = model;
  endtask

  initial begin
    clear_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      start[i]     = 1'b0;
      exp_sig[i]   = 8'd0;
      drv[i]       = 8'd0;
      loop_mode[i] = 1'b0;
    end
    repeat (3) step();
    for (int i = 0; i < NI; i++) check_zero(i);
    clear_n = 1'b1;
    step();
    for (int i = 0; i < NI; i++) check_zero(i);

    // Looped-back vector stream, then constant and random responses back to back.
    run(0, 64, 2, 1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, ref_sig);
    run(0, 64, 2, 1, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, tmp_sig);
    check("const_zero_sig", sig[0], 8'h00);
    check("const_zero_pass", 8'(pass[0]), 8'd1);
    run(0, 64, 2, 1, 1'b0, 1'b1, 8'h00, 1'b0, 8'h5A, 1'b0, tmp_sig);
    check("const_5a_pass", 8'(pass[0]), 8'd0);
    run(0, 64, 2, 1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, tmp_sig);
    run(0, 64, 2, 1, 1'b0, 1'b0, 8'h00, 1'b0, 8'($urandom), 1'b1, tmp_sig);

    // Short runs for MISR arithmetic and the longer clear phase.
    run(1, 2, 3, 3, 1'b0, 1'b1, 8'hFF, 1'b1, 8'h00, 1'b0, tmp_sig);
    check("misr_two_ff", sig[1], 8'h01);
    run(2, 1, 1, 1, 1'b0, 1'b1, 8'hFF, 1'b1, 8'h00, 1'b0, tmp_sig);
    check("misr_one_ff", sig[2], 8'hFF);
    for (int r = 0; r < 3; r++) run(1, 2, 3, 3, 1'b0, 1'b0, 8'h00, r[0], 8'($urandom), 1'b1, tmp_sig);
    for (int r = 0; r < 2; r++) run(2, 1, 1, 1, 1'b0, 1'b0, 8'h00, r[0], 8'($urandom), 1'b1, tmp_sig);

    // Asynchronous reset in the middle of DRIVE, then an uninterrupted rerun.
    loop_mode[0] = 1'b1;
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    for (int i = 0; i < 100 && vcnt[0] != 8'd10; i++) step();
    check("reset_wait_vcnt", vcnt[0], 8'd10);
    #2;
    clear_n = 1'b0;
    #1;
    check_zero(0);
    step();
    check_zero(0);
    clear_n = 1'b1;
    step();
    run(0, 64, 2, 1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, tmp_sig);
    check("rerun_sig", sig[0], ref_sig);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
